// File: rtl/somador_com_sinal_acumulador.sv
// Two-stage pipelined signed/unsigned adder-subtractor with an internal accumulator,
// saturating or wrapping result and overflow flag, valid/ready on both sides.
module somador_com_sinal_acumulador #(
    parameter int LARGURA_A = 8,
    parameter int LARGURA_B = 4,
    parameter int LARGURA_S = 8,
    parameter bit SATURAR   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 entrada_valida,
    output logic                 entrada_pronta,
    input  logic [LARGURA_A-1:0] entrada_a,
    input  logic [LARGURA_B-1:0] entrada_b,
    input  logic [2:0]           codigo,
    output logic                 saida_valida,
    input  logic                 saida_pronta,
    output logic [LARGURA_S-1:0] saida,
    output logic                 overflow
);

    localparam int MAX_AB = (LARGURA_A > LARGURA_B) ? LARGURA_A : LARGURA_B;
    localparam int W      = ((MAX_AB > LARGURA_S) ? MAX_AB : LARGURA_S) + 2;

    localparam logic signed [W-1:0] UM      = W'(1);
    localparam logic signed [W-1:0] MAX_SIN = (UM <<< (LARGURA_S - 1)) - UM;
    localparam logic signed [W-1:0] MIN_SIN = -(UM <<< (LARGURA_S - 1));
    localparam logic signed [W-1:0] MAX_USN = (UM <<< LARGURA_S) - UM;
    localparam logic signed [W-1:0] MIN_USN = '0;

    typedef enum logic [2:0] {
        OP_SOMA_SS  = 3'b000,
        OP_SOMA_UU  = 3'b001,
        OP_SOMA_US  = 3'b010,
        OP_SUB_SS   = 3'b011,
        OP_ACC_S    = 3'b100,
        OP_ACC_U    = 3'b101,
        OP_ZERA     = 3'b110,
        OP_CARREGA  = 3'b111
    } codigo_t;

    // Stage 1 state
    logic                 s1_valida_reg;
    logic signed [W-1:0]  s1_a_reg;
    logic signed [W-1:0]  s1_b_reg;
    codigo_t              s1_codigo_reg;

    // Stage 2 state
    logic                 saida_valida_reg;
    logic [LARGURA_S-1:0] saida_reg;
    logic                 overflow_reg;
    logic [LARGURA_S-1:0] acc_reg;

    logic                 avanca;
    logic signed [W-1:0]  a_ext;
    logic signed [W-1:0]  b_ext;
    logic signed [W-1:0]  acc_ext;
    logic signed [W-1:0]  verdadeiro;
    logic signed [W-1:0]  limite_sup;
    logic signed [W-1:0]  limite_inf;
    logic                 resultado_com_sinal;
    logic                 acc_atualiza;
    logic                 acima;
    logic                 abaixo;
    logic [LARGURA_S-1:0] saida_next;
    logic                 overflow_next;

    // A single global advance signal stalls both stages together.
    assign avanca         = !saida_valida_reg || saida_pronta;
    assign entrada_pronta = avanca;
    assign saida_valida   = saida_valida_reg;
    assign saida          = saida_reg;
    assign overflow       = overflow_reg;

    // Operand extension according to the interpretation each code gives A and B.
    always_comb begin
        a_ext = {{(W-LARGURA_A){1'b0}}, entrada_a};
        b_ext = '0;
        case (codigo)
            OP_SOMA_SS, OP_SUB_SS, OP_ACC_S, OP_CARREGA:
                a_ext = {{(W-LARGURA_A){entrada_a[LARGURA_A-1]}}, entrada_a};
            default:
                a_ext = {{(W-LARGURA_A){1'b0}}, entrada_a};
        endcase
        case (codigo)
            OP_SOMA_SS, OP_SOMA_US, OP_SUB_SS:
                b_ext = {{(W-LARGURA_B){entrada_b[LARGURA_B-1]}}, entrada_b};
            OP_SOMA_UU:
                b_ext = {{(W-LARGURA_B){1'b0}}, entrada_b};
            default:
                b_ext = '0;
        endcase
    end

    // Stage 2 arithmetic on the W-bit signed intermediate.
    always_comb begin
        verdadeiro          = '0;
        resultado_com_sinal = 1'b1;
        acc_atualiza        = 1'b0;
        acc_ext             = {{(W-LARGURA_S){acc_reg[LARGURA_S-1]}}, acc_reg};
        case (s1_codigo_reg)
            OP_SOMA_SS: verdadeiro = s1_a_reg + s1_b_reg;
            OP_SOMA_UU: begin
                verdadeiro          = s1_a_reg + s1_b_reg;
                resultado_com_sinal = 1'b0;
            end
            OP_SOMA_US: verdadeiro = s1_a_reg + s1_b_reg;
            OP_SUB_SS:  verdadeiro = s1_a_reg - s1_b_reg;
            OP_ACC_S: begin
                verdadeiro   = acc_ext + s1_a_reg;
                acc_atualiza = 1'b1;
            end
            OP_ACC_U: begin
                acc_ext             = {{(W-LARGURA_S){1'b0}}, acc_reg};
                verdadeiro          = acc_ext + s1_a_reg;
                resultado_com_sinal = 1'b0;
                acc_atualiza        = 1'b1;
            end
            OP_ZERA: begin
                verdadeiro   = '0;
                acc_atualiza = 1'b1;
            end
            OP_CARREGA: begin
                verdadeiro   = s1_a_reg;
                acc_atualiza = 1'b1;
            end
            default: verdadeiro = '0;
        endcase
    end

    // Range check, then clamp or wrap into LARGURA_S bits.
    always_comb begin
        limite_sup    = resultado_com_sinal ? MAX_SIN : MAX_USN;
        limite_inf    = resultado_com_sinal ? MIN_SIN : MIN_USN;
        acima         = verdadeiro > limite_sup;
        abaixo        = verdadeiro < limite_inf;
        overflow_next = acima || abaixo;
        saida_next    = verdadeiro[LARGURA_S-1:0];
        if (SATURAR) begin
            if (acima) begin
                saida_next = limite_sup[LARGURA_S-1:0];
            end else if (abaixo) begin
                saida_next = limite_inf[LARGURA_S-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valida_reg    <= 1'b0;
            s1_a_reg         <= '0;
            s1_b_reg         <= '0;
            s1_codigo_reg    <= OP_SOMA_SS;
            saida_valida_reg <= 1'b0;
            saida_reg        <= '0;
            overflow_reg     <= 1'b0;
            acc_reg          <= '0;
        end else if (avanca) begin
            s1_valida_reg <= entrada_valida;
            if (entrada_valida) begin
                s1_a_reg      <= a_ext;
                s1_b_reg      <= b_ext;
                s1_codigo_reg <= codigo_t'(codigo);
            end
            saida_valida_reg <= s1_valida_reg;
            // Bubbles leave the result registers and the accumulator untouched.
            if (s1_valida_reg) begin
                saida_reg    <= saida_next;
                overflow_reg <= overflow_next;
                if (acc_atualiza) begin
                    acc_reg <= saida_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_somador_com_sinal_acumulador.sv
// Scoreboard bench: a saturating and a wrapping instance share stimulus; expected
// results are queued on input transfer and compared on output transfer.
module tb_somador_com_sinal_acumulador;

    logic       clk = 1'b0;
    logic       rst;
    logic       entrada_valida;
    logic       entrada_pronta;
    logic       entrada_pronta_w;
    logic [7:0] entrada_a;
    logic [3:0] entrada_b;
    logic [2:0] codigo;
    logic       saida_valida;
    logic       saida_valida_w;
    logic       saida_pronta;
    logic [7:0] saida;
    logic [7:0] saida_w;
    logic       overflow;
    logic       overflow_w;

    somador_com_sinal_acumulador #(.LARGURA_A(8), .LARGURA_B(4), .LARGURA_S(8), .SATURAR(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .entrada_valida(entrada_valida), .entrada_pronta(entrada_pronta),
        .entrada_a(entrada_a), .entrada_b(entrada_b), .codigo(codigo),
        .saida_valida(saida_valida), .saida_pronta(saida_pronta),
        .saida(saida), .overflow(overflow)
    );

    somador_com_sinal_acumulador #(.LARGURA_A(8), .LARGURA_B(4), .LARGURA_S(8), .SATURAR(1'b0)) u_dut_w (
        .clk(clk), .rst(rst),
        .entrada_valida(entrada_valida), .entrada_pronta(entrada_pronta_w),
        .entrada_a(entrada_a), .entrada_b(entrada_b), .codigo(codigo),
        .saida_valida(saida_valida_w), .saida_pronta(saida_pronta),
        .saida(saida_w), .overflow(overflow_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s_sat;
        logic       ovf_sat;
        logic [7:0] s_wrap;
        logic       ovf_wrap;
        int         ciclo;
        bit         mede_latencia;
    } esperado_t;

    esperado_t  fila[$];
    esperado_t  e_mon;
    logic [7:0] acc_sat;
    logic [7:0] acc_wrap;
    int         ciclo_reg = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mede_latencia = 1'b0;

    always @(posedge clk) ciclo_reg <= ciclo_reg + 1;

    task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            errors++;
            $display("FAIL %s: obtido %0h esperado %0h (t=%0t)", tag, obtido, esperado, $time);
        end
    endtask

    // Reference: plain integer arithmetic on 8-bit result, 8-bit A, 4-bit B.
    function automatic void modelo(input logic [2:0] cod, input logic [7:0] a, input logic [3:0] b,
                                   input bit sat, inout logic [7:0] acc,
                                   output logic [7:0] s, output logic ovf);
        int as_v, au_v, bs_v, bu_v, t, lo, hi;
        bit com_sinal;
        as_v = int'($signed(a));
        au_v = int'(a);
        bs_v = int'($signed(b));
        bu_v = int'(b);
        com_sinal = 1'b1;
        case (cod)
            3'd0: t = as_v + bs_v;
            3'd1: begin t = au_v + bu_v; com_sinal = 1'b0; end
            3'd2: t = au_v + bs_v;
            3'd3: t = as_v - bs_v;
            3'd4: t = int'($signed(acc)) + as_v;
            3'd5: begin t = int'(acc) + au_v; com_sinal = 1'b0; end
            3'd6: t = 0;
            default: t = as_v;
        endcase
        lo  = com_sinal ? -128 : 0;
        hi  = com_sinal ? 127 : 255;
        ovf = (t < lo) || (t > hi);
        if (sat && t > hi)      s = hi[7:0];
        else if (sat && t < lo) s = lo[7:0];
        else                    s = t[7:0];
        if (cod[2]) acc = s;
    endfunction

    // Monitor: sampled on the falling edge, transfers happen on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (entrada_valida && entrada_pronta) begin
                modelo(codigo, entrada_a, entrada_b, 1'b1, acc_sat, e_mon.s_sat, e_mon.ovf_sat);
                modelo(codigo, entrada_a, entrada_b, 1'b0, acc_wrap, e_mon.s_wrap, e_mon.ovf_wrap);
                e_mon.ciclo = ciclo_reg;
                e_mon.mede_latencia = mede_latencia;
                fila.push_back(e_mon);
            end
            if (saida_valida && saida_pronta) begin
                if (fila.size() == 0) begin
                    verifica("saida_inesperada", 32'd1, 32'd0);
                end else begin
                    e_mon = fila.pop_front();
                    verifica("saida", saida, e_mon.s_sat);
                    verifica("overflow", overflow, e_mon.ovf_sat);
                    verifica("valida_wrap", saida_valida_w, 1'b1);
                    verifica("saida_wrap", saida_w, e_mon.s_wrap);
                    verifica("overflow_wrap", overflow_w, e_mon.ovf_wrap);
                    if (e_mon.mede_latencia)
                        verifica("latencia", ciclo_reg - e_mon.ciclo, 32'd2);
                    $display("resultado: saida=%02h ovf=%0b saida_wrap=%02h ovf_wrap=%0b",
                             saida, overflow, saida_w, overflow_w);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic envia(input logic [2:0] c, input logic [7:0] a, input logic [3:0] b);
        bit aceito;
        aceito = 1'b0;
        entrada_valida = 1'b1;
        codigo = c;
        entrada_a = a;
        entrada_b = b;
        for (int i = 0; i < 50 && !aceito; i++) begin
            @(negedge clk);
            if (entrada_pronta) aceito = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!aceito) verifica("timeout_entrada", 32'd0, 32'd1);
    endtask

    task automatic esvazia();
        for (int i = 0; i < 100 && fila.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        verifica("fila_vazia", fila.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        entrada_valida = 1'b0;
        entrada_a = '0;
        entrada_b = '0;
        codigo = '0;
        saida_pronta = 1'b1;
        acc_sat = '0;
        acc_wrap = '0;
        repeat (3) @(posedge clk);
        #1;
        verifica("reset_valida", saida_valida, 1'b0);
        verifica("reset_saida", saida, 8'h00);
        verifica("reset_overflow", overflow, 1'b0);
        rst = 1'b0;
        #1;
        verifica("pronta_apos_reset", entrada_pronta, 1'b1);
        @(posedge clk);
        #1;

        // Basic signed add with latency measurement
        mede_latencia = 1'b1;
        envia(3'b000, 8'hF6, 4'hD);
        mede_latencia = 1'b0;
        entrada_valida = 1'b0;
        esvazia();

        // Unsigned, signed and mixed range boundaries, back-to-back
        envia(3'b001, 8'd250, 4'd15);
        envia(3'b000, 8'h80, 4'hF);
        envia(3'b011, 8'h7F, 4'h8);
        envia(3'b010, 8'd200, 4'h8);
        envia(3'b010, 8'd100, 4'h8);
        entrada_valida = 1'b0;
        esvazia();

        // Accumulator chain, with a bubble before the last accumulate
        envia(3'b110, 8'd0, 4'd0);
        envia(3'b100, 8'd100, 4'd0);
        envia(3'b100, 8'd100, 4'd0);
        envia(3'b100, 8'd100, 4'd0);
        envia(3'b111, 8'hF0, 4'd0);
        entrada_valida = 1'b0;
        @(posedge clk);
        #1;
        envia(3'b100, 8'd5, 4'd0);
        envia(3'b101, 8'd200, 4'd3);
        entrada_valida = 1'b0;
        esvazia();

        // Mixed codes under random backpressure
        fork
            begin
                for (int i = 0; i < 24; i++)
                    envia(3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom));
                entrada_valida = 1'b0;
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    #1;
                    saida_pronta = ($urandom_range(0, 3) != 0);
                end
                saida_pronta = 1'b1;
            end
        join
        saida_pronta = 1'b1;
        esvazia();

        // Three-cycle stall with a pending input
        saida_pronta = 1'b0;
        envia(3'b000, 8'd10, 4'd3);
        envia(3'b001, 8'd20, 4'd4);
        fork
            begin
                envia(3'b011, 8'd30, 4'd5);
                envia(3'b010, 8'd40, 4'hE);
                entrada_valida = 1'b0;
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    verifica("pronta_em_stall", entrada_pronta, 1'b0);
                    verifica("valida_em_stall", saida_valida, 1'b1);
                    verifica("saida_em_stall", saida, (fila.size() != 0) ? fila[0].s_sat : 8'hXX);
                end
                @(posedge clk);
                #1;
                saida_pronta = 1'b1;
            end
        join
        esvazia();

        // Reset mid-stream
        envia(3'b100, 8'd50, 4'd0);
        envia(3'b100, 8'd50, 4'd0);
        entrada_valida = 1'b0;
        rst = 1'b1;
        #1;
        verifica("rst_valida", saida_valida, 1'b0);
        verifica("rst_saida", saida, 8'h00);
        verifica("rst_overflow", overflow, 1'b0);
        fila.delete();
        acc_sat = '0;
        acc_wrap = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        envia(3'b100, 8'd1, 4'd0);
        entrada_valida = 1'b0;
        esvazia();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulacao nao terminou");
        $fatal(1);
    end

endmodule
